// File: rtl/cache_axi_read_bridge_if.sv
// AXI4-Lite read-address / read-data channel bundle between the bridge and the
// memory-side slave. Signal names keep the m_axi_ prefix of the master side.
interface cache_axi_read_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [2:0]            m_axi_arprot;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arvalid, m_axi_arprot, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        input  m_axi_araddr, m_axi_arvalid, m_axi_arprot, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
endinterface

// File: rtl/cache_axi_read_bridge.sv
// Single-word cache miss fetch bridge: turns the cache's start pulse into one
// AXI4-Lite read and returns the word with a one-cycle rdy pulse. A HOLD state
// presents the new word one cycle before rdy so the cache's delayed data
// sample lines up with the pulse. One transaction in flight at a time.
module cache_axi_read_bridge #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] ARPROT_VAL = 3'b000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    output logic                  rdy_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_o,
    output logic                  busy_o,
    cache_axi_read_bridge_if.master axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RESP,
        S_HOLD,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rdy_q, rdy_d;
    logic                  busy_q, busy_d;

    // Next-state and datapath; handshake outputs are decoded from the next
    // state so they come straight out of flops.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // word-align the miss address
                    addr_d  = address_i & ~ADDR_WIDTH'(3);
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (axi.m_axi_arready) state_d = S_RESP;
            end
            S_RESP: begin
                if (axi.m_axi_rvalid) begin
                    data_d  = axi.m_axi_rdata;
                    err_d   = (axi.m_axi_rresp != 2'b00);
                    state_d = S_HOLD;
                end
            end
            S_HOLD:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        arvalid_d = (state_d == S_ADDR);
        rready_d  = (state_d == S_RESP);
        rdy_d     = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    assign axi.m_axi_araddr  = addr_q;
    assign axi.m_axi_arvalid = arvalid_q;
    assign axi.m_axi_arprot  = ARPROT_VAL;
    assign axi.m_axi_rready  = rready_q;
    assign rdy_o             = rdy_q;
    assign data_o            = data_q;
    assign err_o             = err_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_cache_axi_read_bridge.sv
// Bench for cache_axi_read_bridge: the bench plays the AXI slave with chosen
// stall counts and predicts every output cycle from the fetch timing rules
// (araddr from T+1, accept after aw stalls, capture after rw stalls,
// data visible one cycle before the single rdy pulse).
module tb_cache_axi_read_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] address_i = '0;
    logic        rdy_o;
    logic [31:0] data_o;
    logic        err_o;
    logic        busy_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] prev_data = '0;

    cache_axi_read_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    cache_axi_read_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ARPROT_VAL(3'b000)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .address_i (address_i),
        .rdy_o     (rdy_o),
        .data_o    (data_o),
        .err_o     (err_o),
        .busy_o    (busy_o),
        .axi       (axi.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic slave_quiet();
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rdata   = '0;
        axi.m_axi_rresp   = 2'b00;
    endtask

    task automatic chk_reset();
        chk("rst_rdy",     rdy_o, 0);
        chk("rst_err",     err_o, 0);
        chk("rst_busy",    busy_o, 0);
        chk("rst_data",    data_o, 0);
        chk("rst_araddr",  axi.m_axi_araddr, 0);
        chk("rst_arvalid", axi.m_axi_arvalid, 0);
        chk("rst_rready",  axi.m_axi_rready, 0);
        chk("rst_arprot",  axi.m_axi_arprot, 0);
    endtask

    // Ends at a negedge with reset just released.
    task automatic reset_dut();
        @(negedge clk_i);
        rst_i = 1'b1; start_i = 1'b0; slave_quiet();
        @(negedge clk_i);
        chk_reset();
        rst_i = 1'b0;
        prev_data = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            chk("idle_busy",    busy_o, 0);
            chk("idle_rdy",     rdy_o, 0);
            chk("idle_arvalid", axi.m_axi_arvalid, 0);
            chk("idle_rready",  axi.m_axi_rready, 0);
        end
    endtask

    // Called at a negedge of an idle cycle T. aw/rw: arready/rvalid low cycles.
    // noise: random start pulses while busy and junk rvalid before accept.
    // abort_at: cycle offset at which reset is asserted (0 = none).
    task automatic fetch(input logic [31:0] addr, input int aw, input int rw,
                         input logic [31:0] rd, input logic [1:0] rr,
                         input bit noise, input int abort_at);
        int          done_k;
        logic [31:0] exp_a;
        done_k = 4 + aw + rw;
        exp_a  = addr & 32'hFFFF_FFFC;
        chk("pre_busy", busy_o, 0);
        chk("pre_rdy",  rdy_o, 0);
        start_i   = 1'b1;
        address_i = addr;
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk_i);
            chk("arvalid", axi.m_axi_arvalid, (k <= 1 + aw));
            if (k <= 1 + aw) chk("araddr", axi.m_axi_araddr, exp_a);
            chk("rready", axi.m_axi_rready, (k >= 2 + aw && k <= 2 + aw + rw));
            chk("rdy",    rdy_o, (k == done_k));
            chk("busy",   busy_o, 1);
            chk("data",   data_o, (k >= 3 + aw + rw) ? rd : prev_data);
            if (k == done_k) chk("err", err_o, (rr != 2'b00));
            if (k == abort_at) begin
                rst_i = 1'b1; start_i = 1'b0; slave_quiet();
                @(negedge clk_i);
                chk_reset();
                rst_i = 1'b0;
                prev_data = '0;
                return;
            end
            start_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            address_i = $urandom;
            axi.m_axi_arready = (k == 1 + aw);
            if (k == 2 + aw + rw) begin
                axi.m_axi_rvalid = 1'b1;
                axi.m_axi_rdata  = rd;
                axi.m_axi_rresp  = rr;
            end else begin
                axi.m_axi_rvalid = noise && (k <= 1 + aw) && ($urandom_range(0, 1) == 1);
                axi.m_axi_rdata  = $urandom;
                axi.m_axi_rresp  = 2'($urandom_range(0, 3));
            end
        end
        start_i = 1'b0;
        slave_quiet();
        prev_data = rd;
    endtask

    initial begin
        slave_quiet();
        reset_dut();
        // zero-wait slave, unaligned address
        fetch(32'h0001_2347, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 0);
        idle(1);
        // stalled slave: rdy at T+12
        fetch(32'h0000_1000, 5, 3, 32'hCAFE_0001, 2'b00, 1'b0, 0);
        idle(2);
        // error response then OKAY
        fetch(32'h0000_2002, 1, 0, 32'h1234_5678, 2'b10, 1'b0, 0);
        idle(1);
        fetch(32'h0000_2006, 0, 1, 32'h0BAD_F00D, 2'b00, 1'b0, 0);
        idle(1);
        // starts while busy, junk rvalid in ADDR
        fetch(32'h0000_3001, 2, 2, 32'h5555_AAAA, 2'b00, 1'b1, 0);
        idle(1);
        // reset in RESP, then immediate start
        fetch(32'h0000_4000, 0, 3, 32'h7777_7777, 2'b00, 1'b0, 3);
        fetch(32'h0000_4444, 0, 0, 32'h8888_1111, 2'b00, 1'b0, 0);
        // back-to-back and randomized traffic
        for (int i = 0; i < 40; i++) begin
            idle(1 + ((i % 3 == 0) ? 0 : $urandom_range(0, 2)));
            fetch($urandom, $urandom_range(0, 4), $urandom_range(0, 4), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
        end
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_axi_read_bridge.md
CACHE_AXI_READ_BRIDGE -- requirements
Module: cache_axi_read_bridge

Interface
REQ-001 The block SHALL have the parameter ADDR_WIDTH, default 32, giving the byte address width on both sides.
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 32, giving the word width; only 32 is supported.
REQ-003 The block SHALL have the parameter ARPROT_VAL, default 3'b000, driven constant on m_axi_arprot.
REQ-004 The block SHALL have the port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have the port start_i, input, 1 bit: the cache's fetch request pulse (cache axi_start_o).
REQ-007 The block SHALL have the port address_i, input, ADDR_WIDTH bits: the miss byte address (cache axi_address_o).
REQ-008 The block SHALL have the port rdy_o, output, 1 bit: the one-cycle fetch-complete pulse (cache axi_rdy_i).
REQ-009 The block SHALL have the port data_o, output, DATA_WIDTH bits: the fetched word (cache axi_data_i).
REQ-010 The block SHALL have the port err_o, output, 1 bit: the response-error flag, qualified by rdy_o.
REQ-011 The block SHALL have the port busy_o, output, 1 bit: high whenever the FSM is not IDLE.
REQ-012 The block SHALL have the AXI4-Lite read-master ports: m_axi_araddr out ADDR_WIDTH; m_axi_arvalid out 1; m_axi_arready in 1; m_axi_arprot out 3; m_axi_rdata in DATA_WIDTH; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.

Function
REQ-013 The FSM SHALL have the states IDLE, ADDR, RESP, HOLD and DONE.
REQ-014 IDLE: when start_i=1, the block SHALL register address_i with bits [1:0] forced to 0 and go to ADDR next cycle.
REQ-015 start_i SHALL be ignored in every state other than IDLE, with no queuing.
REQ-016 ADDR: m_axi_arvalid=1 and m_axi_araddr=registered address; m_axi_araddr SHALL stay stable until m_axi_arready=1, then the FSM goes to RESP.
REQ-017 arvalid SHALL never depend combinationally on arready.
REQ-018 RESP: m_axi_rready=1.
REQ-019 RESP: on m_axi_rvalid=1 the block SHALL register m_axi_rdata into the data register and set the error register to (m_axi_rresp != 2'b00), then go to HOLD.
REQ-020 rready SHALL be 0 in every state except RESP.
REQ-021 HOLD: data_o SHALL already show the new word, with rdy_o=0, for exactly one cycle; then the FSM goes to DONE.
REQ-022 The purpose of HOLD is that the cache's one-cycle delayed data sample is valid when rdy_o arrives.
REQ-023 DONE: rdy_o=1 for exactly one cycle and err_o=error register; then the FSM goes to IDLE.
REQ-024 data_o SHALL hold the last fetched word from HOLD until the next capture in RESP, and SHALL be stable through DONE.
REQ-025 Minimum latency: start_i in cycle T gives rdy_o in cycle T+4 (arready in T+1, rvalid in T+2).
REQ-026 rdy_o SHALL never occur before T+3, which satisfies the cache's rule of no rdy within 3 cycles.
REQ-027 Latency SHALL grow one cycle per arready-low cycle in ADDR and per rvalid-low cycle in RESP; there is no timeout.
REQ-028 rvalid asserted in ADDR (before address acceptance) SHALL be ignored, since rready=0.
REQ-029 An error response SHALL still complete normally (rdy_o pulse, data_o=rdata) with err_o=1; there are no retries.
REQ-030 Only one outstanding transaction SHALL exist at any time.
REQ-031 busy_o SHALL equal (state != IDLE).
REQ-032 Reset mid-transaction SHALL abandon the transaction with no rdy_o; AXI-side recovery relies on a system-wide reset.

Reset
REQ-033 On rst_i=1 at a clock edge: state=IDLE; rdy_o=0; err_o=0; busy_o=0; data_o=0; m_axi_araddr=0; m_axi_arvalid=0; m_axi_rready=0.
REQ-034 rst_i SHALL take priority over start_i in the same cycle.
REQ-035 In the first cycle after rst_i falls the block SHALL accept start_i.

Verification
REQ-036 Zero-wait slave: start_i with address_i=0x0001_2347 at T -> araddr=0x0001_2344 at T+1; rvalid with rdata=0xDEAD_BEEF at T+2; data_o=0xDEAD_BEEF from T+3; rdy_o=1 only at T+4; err_o=0.
REQ-037 Stalled slave: arready held low 5 cycles, rvalid delayed 3 cycles -> araddr and arvalid stable throughout, rready high only in RESP, rdy_o exactly one pulse at T+12.
REQ-038 Error response: rresp=2'b10 with rdata=0x1234_5678 -> rdy_o pulse with err_o=1 and data_o=0x1234_5678; the next OKAY fetch gives err_o=0.
REQ-039 start_i pulsed while busy (in ADDR and in RESP) -> ignored; exactly one AR handshake and one rdy_o pulse.
REQ-040 rst_i asserted in RESP -> next cycle all outputs at reset values with no rdy_o; a start_i immediately after reset completes with the T+4 timing.
REQ-041 Back-to-back: a new start_i in the cycle after rdy_o -> the second fetch completes at T+4, and data_o holds the first word until the second capture.
